// File: rtl/imem_pkg.sv
// Shared constants, state encoding and sizing helper
// for the fetch-stage instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port synchronous RAM with registered,
// read-enabled output; contents are never reset.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/memoria_instrucoes_param.sv
// Fetch-stage instruction memory: clear sweep, valid/ready fetch,
// flush and program load. Optional IMEM_BOUNDS_CHECK_EN.
module memoria_instrucoes_param
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instrucao,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              instr_erro,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              pronto
);

  localparam int IW = idx_w(DEPTH);

  state_t            state;
  logic [IW-1:0]     cnt;
  logic              err_q;
  logic [IW-1:0]     fidx;
  logic [IW-1:0]     lidx;
  logic              fbad;
  logic              lbad;
  logic              accept;
  logic              clr;
  logic              ram_we;
  logic [IW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] rdata;

  assign fidx = fetch_addr[IW+1:2];
  assign lidx = load_addr[IW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  assign fbad = (fetch_addr[1:0] != 2'b00)
             || ((fetch_addr >> (IW + 2)) != '0);
  assign lbad = (load_addr[1:0] != 2'b00)
             || ((load_addr >> (IW + 2)) != '0);
`else
  logic unused_addr;
  assign unused_addr = ^{fetch_addr[1:0],
                         fetch_addr[ADDR_W-1:IW+2],
                         load_addr[1:0],
                         load_addr[ADDR_W-1:IW+2]};
  assign fbad = 1'b0;
  assign lbad = 1'b0;
`endif

  assign clr = (state == S_CLEAR);

  assign fetch_ready = !clr && !load_en
                    && (!instr_valid || instr_ready || flush);

  assign accept = fetch_req && fetch_ready;

  // One shared RAM port: sweep, then load, then fetch read.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = fidx;
    ram_wdata = load_data;
    unique case (1'b1)
      clr: begin
        ram_we    = 1'b1;
        ram_addr  = cnt;
        ram_wdata = DATA_W'(NOP);
      end
      (load_en && !clr): begin
        ram_we   = !lbad;
        ram_addr = lidx;
      end
      default: ;
    endcase
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (accept),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_CLEAR;
      cnt         <= '0;
      pronto      <= 1'b0;
      instr_valid <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pronto <= (state == S_IDLE);
      unique case (state)
        S_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == IW'(DEPTH - 1)) state <= S_IDLE;
        end
        S_IDLE: ;
        default: state <= S_CLEAR;
      endcase
      if (accept) begin
        instr_valid <= 1'b1;
        err_q       <= fbad;
      end else if (instr_ready || flush) begin
        instr_valid <= 1'b0;
      end
    end
  end

  // A faulted fetch presents NOP regardless of what the RAM read.
  assign instrucao  = err_q ? DATA_W'(NOP) : rdata;
  assign instr_erro = err_q;

endmodule

// File: tb/tb_memoria_instrucoes_param.sv
// Directed self-checking bench for memoria_instrucoes_param.
// Covers both IMEM_BOUNDS_CHECK_EN builds.
module tb_memoria_instrucoes_param;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic [31:0] instrucao;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        instr_erro;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        pronto;

  int n_chk  = 0;
  int n_fail = 0;

  memoria_instrucoes_param #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .ADDR_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .instrucao   (instrucao),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_erro  (instr_erro),
    .flush       (flush),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .pronto      (pronto)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic fetch1(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  initial begin
    int bad;
    instr_ready = 1'b1;
    repeat (2) tick();
    check("rst_instr", instrucao, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'h0);
    check("rst_erro", 32'(instr_erro), 32'h0);
    check("rst_pronto", 32'(pronto), 32'h0);
    check("rst_ready", 32'(fetch_ready), 32'h0);

    // sweep: edges 1..DEPTH-1 still clearing
    rst = 1'b0;
    fetch_req = 1'b1;
    fetch_addr = 32'h10;
    #1;
    bad = (fetch_ready !== 1'b0) ? 1 : 0;
    for (int k = 1; k < DEPTH; k++) begin
      tick();
      if (fetch_ready !== 1'b0 || instr_valid !== 1'b0) bad++;
    end
    check("sweep_ready_low", 32'(bad), 32'h0);
    fetch_req = 1'b0;
    tick();
    check("sweep_done_ready", 32'(fetch_ready), 32'h1);
    check("sweep_done_pronto", 32'(pronto), 32'h0);
    tick();
    check("pronto_high", 32'(pronto), 32'h1);

    fetch1(32'h10);
    check("f10_valid", 32'(instr_valid), 32'h1);
    check("f10_data", instrucao, 32'h0);
    check("f10_erro", 32'(instr_erro), 32'h0);

    // load blocks a concurrent fetch
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    load_en    = 1'b1;
    #1;
    check("load_blocks_ready", 32'(fetch_ready), 32'h0);
    load(32'h0C, 32'h8D28_0000);
    load(32'h10, 32'h0110_5020);
    load(32'h1C, 32'h8D32_0004);
    fetch_req = 1'b0;
    check("load_no_accept", 32'(instr_valid), 32'h0);

    // back-to-back
    fetch_req  = 1'b1;
    fetch_addr = 32'h0C;
    tick();
    check("b2b0_data", instrucao, 32'h8D28_0000);
    check("b2b0_valid", 32'(instr_valid), 32'h1);
    fetch_addr = 32'h10;
    tick();
    check("b2b1_data", instrucao, 32'h0110_5020);
    check("b2b1_valid", 32'(instr_valid), 32'h1);

    // hold for 3 cycles
    instr_ready = 1'b0;
    fetch_addr  = 32'h0C;
    #1;
    check("hold_ready", 32'(fetch_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_data", instrucao, 32'h0110_5020);
      check("hold_valid", 32'(instr_valid), 32'h1);
      check("hold_ready_c", 32'(fetch_ready), 32'h0);
    end
    instr_ready = 1'b1;
    #1;
    check("resume_ready", 32'(fetch_ready), 32'h1);
    tick();
    check("resume_data", instrucao, 32'h8D28_0000);

    // flush + accept replaces the held word
    instr_ready = 1'b0;
    fetch_addr  = 32'h1C;
    flush       = 1'b1;
    #1;
    check("flush_ready", 32'(fetch_ready), 32'h1);
    tick();
    flush     = 1'b0;
    fetch_req = 1'b0;
    check("flush_data", instrucao, 32'h8D32_0004);
    check("flush_valid", 32'(instr_valid), 32'h1);

    // flush alone kills
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("kill_valid", 32'(instr_valid), 32'h0);
    check("kill_hold", instrucao, 32'h8D32_0004);
    instr_ready = 1'b1;

`ifdef IMEM_BOUNDS_CHECK_EN
    fetch1(32'h402);
    check("oob_erro", 32'(instr_erro), 32'h1);
    check("oob_data", instrucao, 32'h0);
    check("oob_valid", 32'(instr_valid), 32'h1);
    load(32'h400, 32'hDEAD_BEEF);
    load(32'h00E, 32'hCAFE_F00D);
    fetch1(32'h0);
    check("oob_load_drop", instrucao, 32'h0);
    check("oob_erro_clr", 32'(instr_erro), 32'h0);
    fetch1(32'h0C);
    check("mis_load_drop", instrucao, 32'h8D28_0000);
`else
    fetch1(32'h400);
    check("wrap400_data", instrucao, 32'h0);
    check("wrap400_erro", 32'(instr_erro), 32'h0);
    fetch1(32'h40E);
    check("wrap40e_data", instrucao, 32'h8D28_0000);
    check("wrap40e_erro", 32'(instr_erro), 32'h0);
`endif

    // async reset mid-fetch
    fetch1(32'h0C);
    check("pre_rst_data", instrucao, 32'h8D28_0000);
    rst = 1'b1;
    #1;
    check("arst_instr", instrucao, 32'h0);
    check("arst_valid", 32'(instr_valid), 32'h0);
    check("arst_erro", 32'(instr_erro), 32'h0);
    check("arst_pronto", 32'(pronto), 32'h0);
    check("arst_ready", 32'(fetch_ready), 32'h0);
    tick();
    rst = 1'b0;

    // reset again at sweep counter 100
    repeat (100) tick();
    rst = 1'b1;
    #1;
    check("mid_sweep_pronto", 32'(pronto), 32'h0);
    check("mid_sweep_ready", 32'(fetch_ready), 32'h0);
    tick();
    rst = 1'b0;
    bad = 0;
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      if (pronto !== 1'b0) bad++;
    end
    check("resweep_pronto_low", 32'(bad), 32'h0);
    tick();
    check("resweep_pronto", 32'(pronto), 32'h1);
    fetch1(32'h0C);
    check("resweep_clr0c", instrucao, 32'h0);
    fetch1(32'h1C);
    check("resweep_clr1c", instrucao, 32'h0);
    check("resweep_valid", 32'(instr_valid), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
